// File: rtl/fc_gen_pkg.sv
// Shared types, constants and fixed-point helpers for the run-time loadable
// fully-connected layer engine.
package fc_gen_pkg;

    typedef enum logic [1:0] {
        W_LOAD  = 2'd0,
        X_LOAD  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2
    } act_e;

    localparam int LEAKY_SHIFT = 3;

    // Wide enough that N full-scale products plus the bias can never overflow.
    function automatic int acc_width(input int t, input int n);
        return 2 * t + $clog2(n) + 1;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [127:0] acc, input int t);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (t - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (t - 1));
        if (acc > hi) begin
            return hi[63:0];
        end
        if (acc < lo) begin
            return lo[63:0];
        end
        return acc[63:0];
    endfunction

endpackage

// File: rtl/fc_layer_gen_wbank.sv
// One MAC lane: weight RAM and bias registers for neurons r with r%P == lane,
// plus the accumulator and the shift/activation/saturation finalize stage.
module fc_wbank
    import fc_gen_pkg::*;
#(
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int ROWS = 4,
    parameter int FRAC = 0,
    parameter int AW   = 5,
    parameter int RW   = 2
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic signed [T-1:0] w_data,
    input  logic                b_we,
    input  logic [RW-1:0]       b_idx,
    input  logic [AW-1:0]       rd_addr,
    input  logic [RW-1:0]       grp,
    input  logic                acc_init,
    input  logic                mac_en,
    input  logic                fin_en,
    input  logic signed [T-1:0] x_val,
    input  act_e                act,
    output logic signed [T-1:0] result
);
    localparam int ACC_W = acc_width(T, N);

    logic signed [T-1:0]     mem [ROWS*N];
    logic signed [T-1:0]     rd_data;
    logic signed [T-1:0]     bias [ROWS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ACC_W-1:0] act_val;
    logic signed [2*T-1:0]   prod;
    logic signed [T-1:0]     sat_val;

    // Plain RAM, no reset: contents are only trusted after a full reload.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_addr] <= w_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                bias[i] <= '0;
            end
        end else if (b_we) begin
            bias[b_idx] <= w_data;
        end
    end

    assign prod = (2*T)'(rd_data) * (2*T)'(x_val);

    always_comb begin
        acc_sh  = acc >>> FRAC;
        act_val = acc_sh;
        if (acc_sh[ACC_W-1]) begin
            if (act == ACT_RELU) begin
                act_val = '0;
            end else if (act == ACT_LEAKY) begin
                act_val = acc_sh >>> LEAKY_SHIFT;
            end
        end
    end

    assign sat_val = T'(sat(128'(act_val), T));

    // Bias is pre-scaled by FRAC so it lines up with the products' binary point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (acc_init) begin
                acc <= ACC_W'(bias[grp]) <<< FRAC;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (fin_en) begin
                result <= sat_val;
            end
        end
    end

endmodule

// File: rtl/fc_layer_gen.sv
// Fully-connected layer y = act(W*x + b): streamed weight load, x buffer,
// P-lane group compute and in-order result drain.
module fc_layer_gen
    import fc_gen_pkg::*;
#(
    parameter int M    = 16,
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int P    = 4,
    parameter int FRAC = 0
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cfg_act,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic signed [T-1:0] w_data,
    output logic                w_loaded,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                output_valid,
    input  logic                output_ready,
    output logic signed [T-1:0] output_data
);
    localparam int G     = M / P;
    localparam int DEPTH = G * N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(N + 2);

    state_e              state;
    state_e              next_state;
    logic [LW-1:0]       w_lane;
    logic [LW-1:0]       d_idx;
    logic [GW-1:0]       w_brow;
    logic [GW-1:0]       grp;
    logic [NW-1:0]       w_col;
    logic [NW-1:0]       x_cnt;
    logic                w_bias;
    logic [CW-1:0]       cc;
    act_e                act_q;
    logic signed [T-1:0] x_buf [N];
    logic signed [T-1:0] x_cur;
    logic signed [T-1:0] lane_res [P];
    logic                w_fire;
    logic                x_fire;
    logic                y_fire;
    logic                w_last;
    logic                x_last;
    logic                y_last;
    logic                grp_last;
    logic                acc_init;
    logic                mac_en;
    logic                fin_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;

    assign w_last   = w_bias && (w_lane == LW'(P-1)) && (w_brow == GW'(G-1));
    assign x_last   = (x_cnt == NW'(N-1));
    assign y_last   = (d_idx == LW'(P-1));
    assign grp_last = (grp == GW'(G-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= W_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // A pending weight word beats the first x word so a reload can always start.
    always_comb begin
        next_state   = state;
        w_ready      = 1'b0;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        output_data  = '0;
        w_fire       = 1'b0;
        x_fire       = 1'b0;
        y_fire       = 1'b0;
        unique case (state)
            W_LOAD: begin
                w_ready = 1'b1;
                w_fire  = w_valid;
                if (w_fire && w_last) begin
                    next_state = X_LOAD;
                end
            end
            X_LOAD: begin
                w_ready     = (x_cnt == '0);
                input_ready = !(w_ready && w_valid);
                w_fire      = w_valid && w_ready;
                x_fire      = input_valid && input_ready;
                if (w_fire) begin
                    next_state = W_LOAD;
                end else if (x_fire && x_last) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cc == CW'(N+1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                output_valid = 1'b1;
                output_data  = lane_res[d_idx];
                y_fire       = output_ready;
                if (y_fire && y_last) begin
                    next_state = grp_last ? X_LOAD : COMPUTE;
                end
            end
            default: next_state = W_LOAD;
        endcase
    end

    // Weight cursor walks (row group, lane, column) then the bias registers;
    // it always returns to zero, so a reload from X_LOAD starts at weight 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_col    <= '0;
            w_lane   <= '0;
            w_brow   <= '0;
            w_bias   <= 1'b0;
            w_loaded <= 1'b0;
        end else if (w_fire) begin
            if (state == X_LOAD) begin
                w_loaded <= 1'b0;
            end
            if (!w_bias && (w_col != NW'(N-1))) begin
                w_col <= w_col + 1'b1;
            end else begin
                w_col <= '0;
                if (w_lane != LW'(P-1)) begin
                    w_lane <= w_lane + 1'b1;
                end else begin
                    w_lane <= '0;
                    if (w_brow != GW'(G-1)) begin
                        w_brow <= w_brow + 1'b1;
                    end else begin
                        w_brow <= '0;
                        w_bias <= !w_bias;
                        if (w_bias) begin
                            w_loaded <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt <= '0;
            act_q <= ACT_NONE;
            cc    <= '0;
            grp   <= '0;
            d_idx <= '0;
            for (int i = 0; i < N; i++) begin
                x_buf[i] <= '0;
            end
        end else begin
            if (x_fire) begin
                x_buf[x_cnt] <= input_data;
                if (x_last) begin
                    x_cnt <= '0;
                    act_q <= act_e'(cfg_act);
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
            if (state == COMPUTE) begin
                cc <= (cc == CW'(N+1)) ? '0 : cc + 1'b1;
            end
            if (y_fire) begin
                if (y_last) begin
                    d_idx <= '0;
                    grp   <= grp_last ? '0 : grp + 1'b1;
                end else begin
                    d_idx <= d_idx + 1'b1;
                end
            end
        end
    end

    // RAM read for column j is issued one cycle ahead of the MAC that uses x[j].
    always_comb begin
        x_cur = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(cc) == j + 1) begin
                x_cur = x_buf[j];
            end
        end
    end

    assign acc_init = (state == COMPUTE) && (cc == '0);
    assign mac_en   = (state == COMPUTE) && (cc != '0) && (int'(cc) <= N);
    assign fin_en   = (state == COMPUTE) && (cc == CW'(N+1));
    assign wr_addr  = AW'(int'(w_brow) * N + int'(w_col));
    assign rd_addr  = AW'(int'(grp) * N + ((int'(cc) < N) ? int'(cc) : 0));

    for (genvar l = 0; l < P; l++) begin : g_lane
        fc_wbank #(
            .N    (N),
            .T    (T),
            .ROWS (G),
            .FRAC (FRAC),
            .AW   (AW),
            .RW   (GW)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .w_we     (w_fire && !w_bias && (w_lane == LW'(l))),
            .w_addr   (wr_addr),
            .w_data   (w_data),
            .b_we     (w_fire && w_bias && (w_lane == LW'(l))),
            .b_idx    (w_brow),
            .rd_addr  (rd_addr),
            .grp      (grp),
            .acc_init (acc_init),
            .mac_en   (mac_en),
            .fin_en   (fin_en),
            .x_val    (x_cur),
            .act      (act_q),
            .result   (lane_res[l])
        );
    end

endmodule

// File: tb/tb_fc_layer_gen.sv
// Self-checking bench for fc_layer_gen: directed vector table, hand-written
// multi-cycle sequences and randomized vectors against an arithmetic model.
module tb_fc_layer_gen;
    localparam int M    = 4;
    localparam int N    = 2;
    localparam int T    = 16;
    localparam int P    = 2;
    localparam int FRAC = 0;

    logic                clk;
    logic                reset;
    logic [1:0]          cfg_act;
    logic                w_valid;
    logic                w_ready;
    logic signed [T-1:0] w_data;
    logic                w_loaded;
    logic                input_valid;
    logic                input_ready;
    logic signed [T-1:0] input_data;
    logic                output_valid;
    logic                output_ready;
    logic signed [T-1:0] output_data;

    int checks = 0;
    int errors = 0;
    int wm [M][N];
    int bm [M];
    int xm [N];
    int exp_y [M];

    typedef struct {
        int act;
        int x0;
        int x1;
        int y0;
        int y1;
        int y2;
        int y3;
    } vec_t;
    vec_t vecs [4];

    fc_layer_gen #(.M(M), .N(N), .T(T), .P(P), .FRAC(FRAC)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_act      (cfg_act),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .w_loaded     (w_loaded),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: dot product plus bias, then shift, activation and clamp.
    function automatic int ref_y(input int r, input int act);
        longint acc;
        acc = longint'(bm[r]) * (longint'(1) << FRAC);
        for (int j = 0; j < N; j++) begin
            acc += longint'(wm[r][j]) * longint'(xm[j]);
        end
        acc = acc >>> FRAC;
        if (acc < 0 && act == 1) acc = 0;
        if (acc < 0 && act == 2) acc = acc >>> 3;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic load_weights();
        int guard;
        @(negedge clk);
        w_valid = 1'b1;
        for (int k = 0; k < M*N + M; k++) begin
            w_data = (k < M*N) ? 16'(wm[k/N][k%N]) : 16'(bm[k-M*N]);
            guard = 0;
            #1;
            while (!w_ready && guard < 50) begin
                @(negedge clk); #1; guard++;
            end
            if (!w_ready) begin
                checks++; errors++;
                $display("[TB] FAIL w_handshake: w_ready stuck at 0, required 1");
            end
            @(posedge clk); #1;
            if (k == 0) check_output("w_loaded_cleared_on_load", w_loaded, 0);
            if (k == M*N + M - 2) check_output("w_loaded_before_last", w_loaded, 0);
            @(negedge clk);
        end
        w_valid = 1'b0;
        check_output("w_loaded_set", w_loaded, 1);
    endtask

    task automatic send_word_x(input int v);
        int guard = 0;
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = 16'(v);
        #1;
        while (!input_ready && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        if (!input_ready) begin
            checks++; errors++;
            $display("[TB] FAIL x_handshake: input_ready stuck at 0, required 1");
        end
        @(posedge clk); #1;
        input_valid = 1'b0;
    endtask

    // Sends one x vector, checks latency, then collects M outputs against exp_y,
    // optionally holding output_ready low for stall_len cycles at output stall_idx.
    task automatic apply_stimulus(input string name, input int act, input int x0, input int x1,
                                  input int stall_idx, input int stall_len);
        int lat = 0;
        int got = 0;
        int guard = 0;
        bit stalled = 1'b0;
        cfg_act = 2'(act);
        send_word_x(x0);
        send_word_x(x1);
        check_output({name, "_input_ready_low"}, input_ready, 0);
        while (!output_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_output({name, "_latency"}, lat, N + 2);
        while (got < M && guard < 300) begin
            if (got == stall_idx && !stalled && output_valid) begin
                output_ready = 1'b0;
                stalled = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    check_output({name, "_hold_valid"}, output_valid, 1);
                    check_output({name, "_hold_data"}, output_data, exp_y[got]);
                end
                output_ready = 1'b1;
            end
            if (output_valid && output_ready) begin
                check_output($sformatf("%s_y%0d", name, got), output_data, exp_y[got]);
                got++;
            end
            @(posedge clk); #1; guard++;
        end
        if (got < M) begin
            checks++; errors++;
            $display("[TB] FAIL %s_timeout: got %0d outputs, required %0d", name, got, M);
        end
        check_output({name, "_input_ready_again"}, input_ready, 1);
    endtask

    task automatic set_test_weights();
        wm = '{'{1, 2}, '{3, 4}, '{-1, 0}, '{0, -5}};
        bm = '{0, 10, 0, 0};
    endtask

    initial begin
        reset        = 1'b0;
        cfg_act      = 2'd0;
        w_valid      = 1'b0;
        w_data       = '0;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b1;

        vecs[0] = '{0, 5, 6, 17, 49, -5, -30};
        vecs[1] = '{1, 5, 6, 17, 49, 0, 0};
        vecs[2] = '{2, 5, 6, 17, 49, -1, -4};
        vecs[3] = '{3, 5, 6, 17, 49, -5, -30};

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        check_output("rst_w_ready", w_ready, 1);
        check_output("rst_input_ready", input_ready, 0);
        check_output("rst_output_valid", output_valid, 0);
        check_output("rst_output_data", output_data, 0);
        check_output("rst_w_loaded", w_loaded, 0);
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_input_ready", input_ready, 0);

        $display("[TB] weight load and activation table");
        set_test_weights();
        load_weights();
        for (int i = 0; i < 4; i++) begin
            exp_y = '{vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].y3};
            apply_stimulus($sformatf("table%0d", i), vecs[i].act, vecs[i].x0, vecs[i].x1, M, 0);
        end

        $display("[TB] backpressure");
        exp_y = '{17, 49, -5, -30};
        apply_stimulus("stall", 0, 5, 6, 1, 5);

        $display("[TB] saturation");
        wm = '{'{32767, 32767}, '{32767, 32767}, '{32767, 32767}, '{32767, 32767}};
        bm = '{0, 0, 0, 0};
        load_weights();
        exp_y = '{32767, 32767, 32767, 32767};
        apply_stimulus("sat_pos", 0, 32767, 32767, M, 0);
        exp_y = '{-32768, -32768, -32768, -32768};
        apply_stimulus("sat_neg", 0, -32767, -32767, M, 0);

        $display("[TB] identity reload");
        wm = '{'{1, 0}, '{0, 1}, '{0, 0}, '{0, 0}};
        bm = '{0, 0, 0, 0};
        load_weights();
        exp_y = '{7, -3, 0, 0};
        apply_stimulus("ident", 0, 7, -3, M, 0);

        $display("[TB] randomized vectors");
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int r = 0; r < M; r++) begin
                bm[r] = int'($urandom_range(65535)) - 32768;
                for (int j = 0; j < N; j++) begin
                    wm[r][j] = (rnd == 0) ? int'($urandom_range(511)) - 256
                                          : int'($urandom_range(65535)) - 32768;
                end
            end
            load_weights();
            for (int v = 0; v < 4; v++) begin
                int act;
                act = int'($urandom_range(3));
                for (int j = 0; j < N; j++) begin
                    xm[j] = int'($urandom_range(65535)) - 32768;
                end
                for (int r = 0; r < M; r++) begin
                    exp_y[r] = ref_y(r, act);
                end
                apply_stimulus($sformatf("rand%0d_%0d", rnd, v), act, xm[0], xm[1],
                               int'($urandom_range(M)), int'($urandom_range(3, 1)));
            end
        end

        $display("[TB] reset during compute");
        cfg_act = 2'd0;
        send_word_x(5);
        send_word_x(6);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_output("midrst_w_ready", w_ready, 1);
        check_output("midrst_input_ready", input_ready, 0);
        check_output("midrst_output_valid", output_valid, 0);
        check_output("midrst_output_data", output_data, 0);
        check_output("midrst_w_loaded", w_loaded, 0);
        @(negedge clk);
        reset = 1'b1;
        input_valid = 1'b1;
        input_data  = 16'sd9;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check_output("midrst_x_refused", input_ready, 0);
            check_output("midrst_no_output", output_valid, 0);
        end
        input_valid = 1'b0;
        check_output("midrst_still_unloaded", w_loaded, 0);
        set_test_weights();
        load_weights();
        exp_y = '{17, 49, -5, -30};
        apply_stimulus("recover", 0, 5, 6, M, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
